axi_write_burst_slave: RTL
==========================

// Module: axi_write_burst_slave
// PURPOSE
//  AXI write-side burst engine for the 256-byte DDR-controller memory window; counterpart of the read-address path.
//  Accepts one AW burst at a time, consumes W beats, generates per-beat byte addresses (AWSIZE-scaled INCR),
//  drives a registered write port to the memory, and returns one B response per burst.
//  A beat whose address exceeds MAX_ADDR, an illegal AWSIZE/AWBURST, or WLAST misplacement yields SLVERR.
// PARAMETERS
//  DATA_W    64      W data width in bits; byte lanes = DATA_W/8 = 8
//  MAX_ADDR  32'hFF  highest legal byte address; beat addresses above it are errors
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  AWVALID    in   1   write address valid
//  AWREADY    out  1   write address ready
//  AWADDR     in   32  burst start byte address
//  AWLEN      in   8   beats minus one (1..256 beats)
//  AWSIZE     in   3   bytes per beat = 1<<AWSIZE; legal 0..3
//  AWBURST    in   2   2'b01 INCR only; others are errors
//  WVALID     in   1   write data valid
//  WREADY     out  1   write data ready
//  WDATA      in   64  write data
//  WSTRB      in   8   byte strobes
//  WLAST      in   1   final-beat marker from master
//  BVALID     out  1   write response valid
//  BREADY     in   1   write response ready
//  BRESP      out  2   2'b00 OKAY, 2'b10 SLVERR
//  mem_we     out  1   one-cycle memory write pulse
//  mem_addr   out  8   beat byte address [7:0]
//  mem_wdata  out  64  registered WDATA
//  mem_wstrb  out  8   WSTRB AND size/alignment lane mask
// BEHAVIOUR
//  Reset: state IDLE; BVALID=0, BRESP=00, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, WREADY=0.
//   AWREADY=0 while rst high, =1 on first cycle after release (decoded from state).
//  FSM IDLE -> DATA -> RESP -> IDLE; one outstanding burst; AW ignored outside IDLE.
//  IDLE: AWREADY=1. On AWVALID&AWREADY: latch addr=AWADDR, len=AWLEN, size, beat_cnt=0;
//   err=(AWSIZE>3)|(AWBURST!=01). Next state DATA.
//  DATA: WREADY=1. On each WVALID&WREADY:
//   beat_err=(addr>MAX_ADDR); err |= beat_err | (WLAST != (beat_cnt==len)).
//   If !err and !beat_err (pre-update err): next cycle mem_we=1, mem_addr=addr[7:0], mem_wdata=WDATA,
//   mem_wstrb=WSTRB & lane mask (lanes addr[2:0] .. addr[2:0]+(1<<size)-1, clipped at lane 7).
//   Otherwise no mem_we (sticky suppression: after first error no further writes in burst).
//   addr += (1<<size) in 32-bit unsigned arithmetic (wrap at 2^32 is not special; >MAX_ADDR already errors).
//   beat_cnt++. Termination by count: beat_cnt==len handshake -> RESP, regardless of WLAST.
//  Write latency: memory write one cycle after W handshake; mem_we never high two cycles for one beat.
//  RESP: BVALID=1, BRESP=err?10:00, held stable until BREADY; on BVALID&BREADY -> IDLE, BVALID=0 next cycle.
//   BREADY pre-asserted: BVALID still high for exactly one cycle. Minimum burst turnaround 3 cycles.
//  Errored beats are still accepted (WREADY=1) so the master never stalls.
//  rst mid-burst: abandon burst, no B response, pending mem_we cleared, all outputs to reset values.
// TESTING
//  1. AWADDR=0x10,AWLEN=3,AWSIZE=3,INCR, 4 beats WLAST on 4th -> mem_we at 0x10,0x18,0x20,0x28; BRESP=00.
//  2. AWADDR=0xF8,AWLEN=1,AWSIZE=3 -> 1 write at 0xF8, beat 2 (0x100) suppressed; BRESP=10.
//  3. AWSIZE=4, AWLEN=2 -> 3 beats accepted, zero mem_we; BRESP=10. Repeat with AWBURST=2'b10, same result.
//  4. AWADDR=0x03,AWSIZE=1,WSTRB=FF -> mem_wstrb=8'h18; next beat addr 0x05 mem_wstrb=8'h60; WLAST early on beat1 of 2 -> beat2 suppressed, SLVERR.
//  5. BREADY low 5 cycles -> BVALID/BRESP held; AWREADY=0 until B handshake, then 1.
//  6. rst asserted after 2nd of 4 beats -> no further mem_we, no BVALID; new burst after release completes OKAY.

Source files
------------

// File: rtl/axi_write_burst_slave.sv
// -----------------------------------------------------------------------------
// axi_write_burst_slave
//
// Write-side AXI burst engine for the 256-byte DDR-controller memory window.
// It takes one AW burst at a time and consumes its W beats. For each beat it
// generates the byte address (INCR, scaled by AWSIZE) and drives a registered
// one-cycle write port to the memory. It returns one B response per burst.
//
// SLVERR is returned when any of these occur in the burst:
//   - AWSIZE > 3
//   - AWBURST other than INCR
//   - a beat address above MAX_ADDR
//   - WLAST disagreeing with the beat count
//
// After the first error in a burst, all further memory writes for that burst
// are suppressed. Errored beats are still accepted, so the master never stalls.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   AWVALID/AWREADY/AWADDR/AWLEN/
//   AWSIZE/AWBURST                   write address channel
//   WVALID/WREADY/WDATA/WSTRB/WLAST  write data channel
//   BVALID/BREADY/BRESP              write response channel
//   mem_we/mem_addr/mem_wdata/
//   mem_wstrb                        registered memory write port
//                                    (one-cycle pulse per beat)
// -----------------------------------------------------------------------------
module axi_write_burst_slave #(
  parameter int          DATA_W   = 64,
  parameter logic [31:0] MAX_ADDR = 32'hFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [31:0]         AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                WVALID,
  output logic                WREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [1:0]          BRESP,
  output logic                mem_we,
  output logic [7:0]          mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_addr;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [7:0]          r_cnt;
  logic                r_err;
  logic                r_we;
  logic [7:0]          r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [STRB_W-1:0]   r_mem_wstrb;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_b_hs;
  logic                w_last_beat;
  logic                w_beat_err;
  logic                w_wlast_err;
  logic [STRB_W-1:0]   w_lane_mask;
  int                  w_lane;
  int                  w_bytes;

  // Handshake outputs are decoded from the state. They are also forced low
  // while rst is high, so nothing looks ready during reset.
  assign AWREADY = ~rst & (r_state == S_IDLE);
  assign WREADY  = ~rst & (r_state == S_DATA);
  assign BVALID  = ~rst & (r_state == S_RESP);
  assign BRESP   = BVALID ? {r_err, 1'b0} : 2'b00;

  assign w_aw_hs = AWVALID & AWREADY;
  assign w_w_hs  = WVALID & WREADY;
  assign w_b_hs  = BVALID & BREADY;

  assign w_last_beat = (r_cnt == r_len);
  assign w_beat_err  = (r_addr > MAX_ADDR);
  assign w_wlast_err = (WLAST != w_last_beat);

  // Active byte lanes for this beat: from the address's lane offset, for
  // (1 << size) lanes, clipped at the top lane of the bus.
  assign w_lane  = int'(r_addr[LANE_W-1:0]);
  assign w_bytes = int'(32'd1 << r_size);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_lane_mask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      w_lane_mask[i] = (i >= w_lane) && (i < w_lane + w_bytes);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_aw_hs)                 w_state_nxt = S_DATA;
      // The burst ends on the beat count alone; a misplaced WLAST only flags
      // an error.
      S_DATA:  if (w_w_hs && w_last_beat)   w_state_nxt = S_RESP;
      S_RESP:  if (w_b_hs)                  w_state_nxt = S_IDLE;
      default:                              w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= 1'b0;  // single-cycle pulse unless a beat writes below

      if (w_aw_hs) begin
        r_addr <= AWADDR;
        r_len  <= AWLEN;
        r_size <= AWSIZE;
        r_cnt  <= '0;
        r_err  <= AWSIZE[2] | (AWBURST != 2'b01);
      end

      if (w_w_hs) begin
        r_err <= r_err | w_beat_err | w_wlast_err;
        // Write gating uses the error flag from before this beat. A WLAST
        // mismatch on this beat still lets this beat write, but it blocks
        // every later beat in the burst.
        if (!r_err && !w_beat_err) begin
          r_we        <= 1'b1;
          r_mem_addr  <= r_addr[7:0];
          r_mem_wdata <= WDATA;
          r_mem_wstrb <= WSTRB & w_lane_mask;
        end
        r_addr <= r_addr + (32'd1 << r_size);
        r_cnt  <= r_cnt + 8'd1;
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule
